// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, control-register
// bit positions, the default start-phase preload and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int CTRL_ARM     = 7;
    localparam int CTRL_PAR_EN  = 6;
    localparam int CTRL_PAR_ODD = 5;
    localparam int CTRL_LEN9    = 4;
    localparam int CTRL_RST     = 3;

    // Half a bit period of phase, so the first tick lands mid start bit.
    localparam logic [31:0] START_PHASE_DEFAULT = 32'h4000_0000;

    function automatic logic expected_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_accumulator.sv
// Phase accumulator baud generator: adds the increment each clock and emits a
// tick while bit31 is set; the set value is cleared on the following clock.
module uart_baud_accumulator (
    input  logic        clk_i,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] preload,
    input  logic [31:0] increment,
    output logic        tick
);

    logic [31:0] acc;

    always_ff @(posedge clk_i) begin
        if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= preload;
        end else if (acc[31]) begin
            acc <= '0;
        end else begin
            acc <= acc + increment;
        end
    end

    assign tick = acc[31];

endmodule

// File: rtl/uart_rx_module.sv
// UART receiver: synchronised line, start-edge detect, mid-bit sampling from the
// phase accumulator, optional parity and 9-bit words, registered result pulses.
module uart_rx_module
    import uart_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] START_PHASE = START_PHASE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx,
    input  logic [7:0]  rx_ctrl_reg,
    input  logic [31:0] baud_rate_divider_constant,
    output logic [8:0]  rx_data_out,
    output logic        frame_receive_complete,
    output logic        parity_error_flag,
    output logic        frame_error_flag,
    output logic        rx_busy,
    output uart_state_e rx_state
);

    // frame_receive_complete is a single-cycle valid with no ready: the consumer
    // must capture rx_data_out and the error flags in that same cycle.
    logic [SYNC_STAGES-1:0] sync;
    logic                   line, line_d, fall;
    logic                   soft_rst, start_ok, tick, stop_tick;
    logic                   acc_clear, acc_load;
    uart_state_e            state, next_state;
    logic [3:0]             bit_cnt, last_bit;
    logic [8:0]             shift;
    logic                   par_bad, cfg_par_en, cfg_par_odd, cfg_len9;
    logic                   unused_ctrl;

    assign soft_rst    = rst_i | rx_ctrl_reg[CTRL_RST];
    assign unused_ctrl = ^rx_ctrl_reg[2:0];

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            sync   <= '1;
            line_d <= 1'b1;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], uart_rx};
            line_d <= line;
        end
    end

    assign line     = sync[SYNC_STAGES-1];
    assign fall     = line_d & ~line;
    assign start_ok = fall & rx_ctrl_reg[CTRL_ARM] & (baud_rate_divider_constant != 32'd0);
    assign last_bit = cfg_len9 ? 4'd8 : 4'd7;

    uart_baud_accumulator u_baud (
        .clk_i     (clk_i),
        .clear     (acc_clear),
        .load      (acc_load),
        .preload   (START_PHASE),
        .increment (baud_rate_divider_constant),
        .tick      (tick)
    );

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start_ok) next_state = ST_START;
            ST_START:  if (tick) next_state = line ? ST_IDLE : ST_DATA;
            ST_DATA:   if (tick && (bit_cnt == last_bit)) next_state = cfg_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) next_state = ST_STOP;
            ST_STOP:   if (tick) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_load  = 1'b0;
        acc_clear = soft_rst;
        stop_tick = 1'b0;
        rx_busy   = 1'b1;
        case (state)
            ST_IDLE: begin
                rx_busy   = 1'b0;
                acc_load  = start_ok & ~soft_rst;
                acc_clear = soft_rst | ~start_ok;
            end
            ST_STOP: stop_tick = tick & ~soft_rst;
            default: ;
        endcase
    end

    assign rx_state = state;

    // Frame format is captured at the start edge so control writes mid-frame
    // cannot change the length or parity of a frame already in flight.
    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            bit_cnt     <= '0;
            shift       <= '0;
            par_bad     <= 1'b0;
            cfg_par_en  <= 1'b0;
            cfg_par_odd <= 1'b0;
            cfg_len9    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        cfg_par_en  <= rx_ctrl_reg[CTRL_PAR_EN];
                        cfg_par_odd <= rx_ctrl_reg[CTRL_PAR_ODD];
                        cfg_len9    <= rx_ctrl_reg[CTRL_LEN9];
                    end
                end
                ST_START: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        shift   <= '0;
                        par_bad <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift[bit_cnt] <= line;
                        bit_cnt        <= bit_cnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (tick) par_bad <= (line != expected_parity(shift, cfg_par_odd));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_data_out <= 9'h000;
        end else if (stop_tick) begin
            rx_data_out <= shift;
        end
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            frame_receive_complete <= 1'b0;
            parity_error_flag      <= 1'b0;
            frame_error_flag       <= 1'b0;
        end else begin
            frame_receive_complete <= stop_tick;
            parity_error_flag      <= stop_tick & par_bad;
            frame_error_flag       <= stop_tick & ~line;
        end
    end

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module: frames are driven bit by bit, expected
// words are queued by the driver and checked by an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx_module;
    import uart_pkg::*;

    localparam int          BIT = 434;
    localparam logic [31:0] DIV = 32'd4947802;

    logic        clk;
    logic        rst_i;
    logic        uart_rx;
    logic [7:0]  rx_ctrl_reg;
    logic [31:0] baud_rate_divider_constant;
    logic [8:0]  rx_data_out;
    logic        frame_receive_complete;
    logic        parity_error_flag;
    logic        frame_error_flag;
    logic        rx_busy;
    uart_state_e rx_state;

    int          checks   = 0;
    int          failures = 0;
    logic [10:0] exp_q[$];
    logic        complete_prev = 1'b0;
    logic        busy_seen     = 1'b0;

    uart_rx_module dut (
        .clk_i                      (clk),
        .rst_i                      (rst_i),
        .uart_rx                    (uart_rx),
        .rx_ctrl_reg                (rx_ctrl_reg),
        .baud_rate_divider_constant (baud_rate_divider_constant),
        .rx_data_out                (rx_data_out),
        .frame_receive_complete     (frame_receive_complete),
        .parity_error_flag          (parity_error_flag),
        .frame_error_flag           (frame_error_flag),
        .rx_busy                    (rx_busy),
        .rx_state                   (rx_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic hold_line(input logic v, input int n);
        uart_rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_partial(input logic [8:0] data, input int nbits);
        hold_line(1'b0, BIT);
        for (int i = 0; i < nbits; i++) hold_line(data[i], BIT);
        uart_rx = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] ctrl, input logic [8:0] data, input int nbits,
                             input logic par_bit, input logic stop_bit, input logic exp_perr,
                             input int drop_arm_bit, input logic [8:0] exp_data);
        rx_ctrl_reg = ctrl;
        exp_q.push_back({exp_perr, ~stop_bit, exp_data});
        hold_line(1'b0, BIT);
        for (int i = 0; i < nbits; i++) begin
            if (i == drop_arm_bit) rx_ctrl_reg[CTRL_ARM] = 1'b0;
            hold_line(data[i], BIT);
        end
        if (ctrl[CTRL_PAR_EN]) hold_line(par_bit, BIT);
        hold_line(stop_bit, BIT);
        hold_line(1'b1, 20);
        wait_drain(1000);
        check("busy_after_stop", 32'(rx_busy), 32'd0);
        check("data_held", 32'(rx_data_out), 32'(exp_data));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [10:0] e;
        if (!rst_i) begin
            if (frame_receive_complete) begin
                check("pulse_width", 32'(complete_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_complete: got data 0x%0h expected no frame at %0t", rx_data_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data_out), 32'(e[8:0]));
                    check("frame_err", 32'(frame_error_flag), 32'(e[9]));
                    check("parity_err", 32'(parity_error_flag), 32'(e[10]));
                end
            end else if (parity_error_flag || frame_error_flag) begin
                check("flag_without_complete", {30'd0, parity_error_flag, frame_error_flag}, 32'd0);
            end
            if (rx_busy) busy_seen = 1'b1;
        end
        complete_prev = frame_receive_complete;
    end

    // stimulus
    initial begin
        rst_i                      = 1'b1;
        uart_rx                    = 1'b1;
        rx_ctrl_reg                = 8'h80;
        baud_rate_divider_constant = DIV;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("rst_data", 32'(rx_data_out), 32'h000);
        check("rst_complete", 32'(frame_receive_complete), 32'd0);
        check("rst_perr", 32'(parity_error_flag), 32'd0);
        check("rst_ferr", 32'(frame_error_flag), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_state", 32'(rx_state), 32'(ST_IDLE));
        rst_i = 1'b0;
        hold_line(1'b1, 10);

        // 8N1, 8E1 with bad parity, 8O1 with good parity
        run_frame(8'h80, 9'h055, 8, 1'b0, 1'b1, 1'b0, -1, 9'h055);
        run_frame(8'hC0, 9'h0A3, 8, 1'b1, 1'b1, 1'b1, -1, 9'h0A3);
        run_frame(8'hE0, 9'h0A3, 8, 1'b1, 1'b1, 1'b0, -1, 9'h0A3);
        // 9-bit words, second with stop bit forced low
        run_frame(8'h90, 9'h1C5, 9, 1'b0, 1'b1, 1'b0, -1, 9'h1C5);
        run_frame(8'h90, 9'h0F0, 9, 1'b0, 1'b0, 1'b0, -1, 9'h0F0);

        // short low glitch is a false start
        rx_ctrl_reg = 8'h80;
        hold_line(1'b0, 100);
        hold_line(1'b1, 500);
        check("glitch_busy", 32'(rx_busy), 32'd0);
        check("glitch_state", 32'(rx_state), 32'(ST_IDLE));
        run_frame(8'h80, 9'h03C, 8, 1'b0, 1'b1, 1'b0, -1, 9'h03C);

        // disarmed receiver ignores the line
        rx_ctrl_reg = 8'h00;
        busy_seen   = 1'b0;
        send_partial(9'h0FF, 8);
        hold_line(1'b1, BIT + 20);
        check("disarmed_busy_seen", 32'(busy_seen), 32'd0);
        rx_ctrl_reg = 8'h80;
        hold_line(1'b1, 10);

        // control-register reset mid DATA keeps the last word
        send_partial(9'h0AA, 4);
        rx_ctrl_reg = 8'h88;
        @(posedge clk);
        #1;
        rx_ctrl_reg = 8'h80;
        hold_line(1'b1, 3);
        check("soft_rst_busy", 32'(rx_busy), 32'd0);
        check("soft_rst_data_kept", 32'(rx_data_out), 32'h03C);
        hold_line(1'b1, 2 * BIT);

        // rst_i mid DATA clears everything
        send_partial(9'h081, 3);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        hold_line(1'b1, 3);
        check("hard_rst_busy", 32'(rx_busy), 32'd0);
        check("hard_rst_state", 32'(rx_state), 32'(ST_IDLE));
        check("hard_rst_data", 32'(rx_data_out), 32'h000);
        hold_line(1'b1, 2 * BIT);

        // arm dropped mid-frame does not abort it
        run_frame(8'h80, 9'h081, 8, 1'b0, 1'b1, 1'b0, 3, 9'h081);

        hold_line(1'b1, 50);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_module.md
UART_RX_MODULE -- requirements
Module: uart_rx_module

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of flops in the uart_rx synchroniser (minimum 2).
REQ-002 Parameter: START_PHASE, 32'h4000_0000, accumulator preload on start-edge detect (half bit period).
REQ-003 clk_i  in  1  single clock; one clock; reset is synchronous and active-high.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 uart_rx  in  1  asynchronous serial line, idle high, LSB first.
REQ-006 rx_ctrl_reg  in  8  bit7 arm, bit6 parity enable, bit5 odd(1)/even(0), bit4 9-bit data, bit3 rx reset.
REQ-007 baud_rate_divider_constant  in  32  phase increment per clk_i; tick when accumulator bit31 sets.
REQ-008 rx_data_out  out  9  last received word; bit8 = 0 in 8-bit mode.
REQ-009 frame_receive_complete  out  1  one-cycle pulse per completed frame.
REQ-010 parity_error_flag  out  1  one-cycle pulse, coincident with complete, on parity mismatch.
REQ-011 frame_error_flag  out  1  one-cycle pulse, coincident with complete, when stop bit sampled 0.
REQ-012 rx_busy  out  1  high in every state except IDLE.

Function
REQ-013 uart_rx SHALL pass through SYNC_STAGES flops (reset value 1); all logic uses the synchronised value.
REQ-014 Accumulator: each clk_i, if bit31 set then clear, else add divider; tick = bit31 set after update.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: on synchronised 1->0 edge with arm=1 and divider!=0, load START_PHASE into accumulator, go START.
REQ-017 IDLE with arm=0 or divider=0 SHALL ignore the line; accumulator held at 0.
REQ-018 START tick: line 0 -> DATA, bit count 0; line 1 -> IDLE (false start), no output pulses.
REQ-019 DATA tick: sample into bit[count], LSB first; after 8 bits (bit4=0) or 9 bits (bit4=1) go PARITY if bit6=1, else STOP.
REQ-020 PARITY tick: expected = XOR(data bits) when bit5=0, inverted when bit5=1; mismatch latched internally.
REQ-021 STOP tick: sample stop bit; SHALL return to IDLE on that tick (no full stop-bit wait).
REQ-022 Cycle after the STOP tick: rx_data_out updated, frame_receive_complete=1, error flags per REQ-010/011, all for exactly one cycle.
REQ-023 Data SHALL be delivered even with parity or frame error.
REQ-024 rx_data_out SHALL hold its value until the next completion.
REQ-025 arm (bit7) clearing mid-frame SHALL NOT abort the frame; only start detection is gated.
REQ-026 rx_ctrl_reg[3]=1 SHALL behave as rst_i for that cycle, except rx_data_out is retained.
REQ-027 A falling edge already present on the cycle the block enters IDLE SHALL be detected.

Reset
REQ-028 On rst_i: state IDLE, accumulator 0, bit count 0, synchroniser all 1, rx_data_out 9'h000, all pulses and rx_busy 0.
REQ-029 rst_i mid-frame SHALL discard the partial frame without any pulse.

Structure
REQ-030 uart_pkg SHALL hold state encodings, control bit indices (ARM=7, PAR_EN=6, PAR_ODD=5, LEN9=4, RST=3) and START_PHASE.
REQ-031 The accumulator SHALL be a sub-module uart_baud_accumulator (load, preload value, increment, tick), reusable by the TX side.
REQ-032 Target 150-250 lines of RTL; no combinational path from uart_rx to any output.

Verification (clk 50 MHz, divider 32'd4947802, ~434 clk/bit)
REQ-033 8N1, arm=1, send 0x55 -> rx_data_out=9'h055, one complete pulse, parity_err=0, frame_err=0, rx_busy low after STOP.
REQ-034 8E1 (bit6=1, bit5=0), send 0xA3 with parity bit 1 -> rx_data_out=9'h0A3, parity_error_flag pulse with complete.
REQ-035 9-bit mode (bit4=1), send 0x1C5 -> rx_data_out=9'h1C5; stop bit forced 0 on a second frame -> frame_error_flag=1.
REQ-036 Low glitch of 100 clk (< half bit) -> no complete pulse, back in IDLE, following 0x3C frame received correctly.
REQ-037 arm=0, send 0xFF -> no pulse, rx_busy stays 0; rst_i then rx_ctrl_reg[3] asserted mid-DATA -> IDLE, no pulse, next 0x81 frame received correctly.
